mc14433_bcd_latch_scan: RTL and testbench
=========================================

Name: mc14433_bcd_latch_scan

Overview:
Downstream stage of the conversion shift/phase-control logic in the MC14433 3½-digit dual-slope ADC model. It counts P1 clocks while the control stage enables the de-integrate phase, and latches the result plus polarity at end of conversion. It then time-multiplexes the latched BCD digits onto Q[3:0] with one-hot digit strobes DS[4:1], and drives the EOC and ORB pins.

Parameters:
SCAN_DIV, 80, P1 cycles each digit strobe stays active (≥2)
FULL_SCALE, 1999, saturation count; the next increment sets overflow
UR_LIMIT, 180, a latched count below this flags underrange

Ports:
P1  input  1  clock, rising edge
R  input  1  reset, asynchronous, active-low
CNT_EN  input  1  de-integrate count enable from phase control
CNT_CLR  input  1  synchronous counter clear at start of conversion
EOC_IN  input  1  end-of-conversion level from phase control; rising edge is used
POL  input  1  comparator polarity (1 = positive)
DU  input  1  display-update enable, sampled at EOC edge
Q  output  4  multiplexed BCD / status word
DS  output  4  digit strobes, one-hot; DS[0]=DS1 (MSD) … DS[3]=DS4 (LSD)
EOC  output  1  one-cycle end-of-conversion pulse
ORB  output  1  overrange, active-low

Behaviour:
- Reset (R=0, async):
  - counter = 0, overflow = 0.
  - Latches = 0: half, hundreds, tens, units, pol, or, ur.
  - Scan divider = 0, digit index = DS1.
  - Outputs: DS=4'b0001, Q=4'b0000, EOC=0, ORB=1.
  - EOC_IN edge-detect register = 0.
- Counter (all updates on P1 rising edge):
  - Three BCD decades plus a half-digit bit, range 0..1999.
  - CNT_CLR=1: count=0, overflow=0. CNT_CLR has priority over CNT_EN.
  - CNT_EN=1 and count<FULL_SCALE: BCD increment with decimal carry (0009→0010, 0999→1000).
  - CNT_EN=1 at FULL_SCALE: count holds 1999 (saturates), overflow=1.
- Latch:
  - eoc_edge = EOC_IN & ~EOC_IN_d (EOC_IN_d is a registered copy).
  - On the edge where eoc_edge=1:
    - EOC=1 for exactly that following cycle.
    - If DU=1, latch the pre-edge counter value, overflow, and POL.
    - ur = (count < UR_LIMIT) & ~overflow.
  - DU=0: latches hold and EOC still pulses.
  - A simultaneous CNT_CLR still latches the pre-clear value.
  - EOC_IN held high yields a single pulse only.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - At the terminal count it wraps to 0 and the digit index advances DS1→DS2→DS3→DS4→DS1.
  - DS and Q are registered and change on the same edge.
- Q word per strobe:
  - DS1: {half, pol, 1'b0, or|ur}
  - DS2: hundreds
  - DS3: tens
  - DS4: units
- Q updates from new latch contents one cycle after the latch edge, mid-slot if necessary; the scan position is unaffected.
- ORB = ~latched or, registered, same timing as Q.
- Scan runs continuously, independent of counting and EOC.
- Reset mid-scan or mid-count: immediate return to reset values; scan restarts at DS1.

Decomposition:
- Shared package mc14433_pkg:
  - digit-index typedef (2-bit enum DIG1..DIG4)
  - DS one-hot constants
  - BCD nibble typedef
  - default FULL_SCALE / UR_LIMIT constants
- Sub-module bcd_decade: one decade counter with clr, en, carry-in, carry-out, 4-bit value. Instantiated three times; the half digit is a separate flop in the parent.

Test Plan:
1. R low for 3 cycles mid-scan with count 0567 → DS=0001, Q=0000, EOC=0, ORB=1 immediately; after release with SCAN_DIV=4, DS advances 0001→0010→0100→1000→0001 every 4 cycles.
2. CNT_CLR, 1234 CNT_EN cycles, POL=1, DU=1, EOC_IN rise → one-cycle EOC; scan shows DS1 Q=1100, DS2 Q=0010, DS3 Q=0011, DS4 Q=0100; ORB=1.
3. 2005 CNT_EN cycles → latched 1999; DS1 Q=1001 with POL=0; DS2–DS4 Q=1001; ORB=0.
4. 150 CNT_EN cycles, POL=0 → DS1 Q=0001 (underrange), DS2 Q=0001, DS3 Q=0101, DS4 Q=0000; ORB=1.
5. Second conversion of 0042 with DU=0 → EOC pulses, Q still shows 1234 digits; EOC_IN held high 10 cycles → one EOC pulse.
6. CNT_CLR and CNT_EN both high, and EOC_IN rising on the same edge as CNT_CLR at count 0777 → counter=0 next cycle; latched value 0777 (DS2 Q=0111).

Source files
------------

// File: rtl/mc14433_pkg.sv
// +----------------------------------------------------------------------------+
// | mc14433_pkg : shared types and constants for the MC14433 BCD latch / scan  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mc14433_pkg;

  typedef enum logic [1:0] {
    DIG1 = 2'd0,
    DIG2 = 2'd1,
    DIG3 = 2'd2,
    DIG4 = 2'd3
  } dig_t;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] c_ds1 = 4'b0001;
  localparam logic [3:0] c_ds2 = 4'b0010;
  localparam logic [3:0] c_ds3 = 4'b0100;
  localparam logic [3:0] c_ds4 = 4'b1000;

  localparam int unsigned c_full_scale_default = 1999;
  localparam int unsigned c_ur_limit_default   = 180;

  function automatic logic [3:0] ds_onehot(input dig_t dig);
    logic [3:0] ds;
    case (dig)
      DIG1:    ds = c_ds1;
      DIG2:    ds = c_ds2;
      DIG3:    ds = c_ds3;
      default: ds = c_ds4;
    endcase
    return ds;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc14433_bcd_latch_scan_bcd_decade.sv
// +----------------------------------------------------------------------------+
// | bcd_decade : one BCD decade counter, rippled through cin/cout              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_decade
  import mc14433_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_cin,
  output logic o_cout,
  output bcd_t o_value
);

  bcd_t r_value;

  assign o_cout  = i_cin & (r_value == 4'd9);
  assign o_value = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 4'd0;
    end else if (i_clr) begin
      r_value <= 4'd0;
    end else if (i_en && i_cin) begin
      r_value <= (r_value == 4'd9) ? 4'd0 : r_value + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc14433_bcd_latch_scan.sv
// +----------------------------------------------------------------------------+
// | mc14433_bcd_latch_scan : de-integrate counter, EOC latch, digit scanner    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc14433_bcd_latch_scan
  import mc14433_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 80,
  parameter int unsigned FULL_SCALE = c_full_scale_default,
  parameter int unsigned UR_LIMIT   = c_ur_limit_default
) (
  input  logic       P1,
  input  logic       R,
  input  logic       CNT_EN,
  input  logic       CNT_CLR,
  input  logic       EOC_IN,
  input  logic       POL,
  input  logic       DU,
  output logic [3:0] Q,
  output logic [3:0] DS,
  output logic       EOC,
  output logic       ORB
);

  localparam int unsigned      c_div_w    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

  // ---------------- counter ----------------
  bcd_t        w_units;
  bcd_t        w_tens;
  bcd_t        w_hund;
  logic        w_cy_u;
  logic        w_cy_t;
  logic        w_cy_h;
  logic        r_half;
  logic        r_ovf;
  logic [11:0] w_count_bin;
  logic        w_below_fs;
  logic        w_inc;

  assign w_count_bin = 12'(r_half) * 12'd1000 + 12'(w_hund) * 12'd100
                     + 12'(w_tens) * 12'd10   + 12'(w_units);
  assign w_below_fs  = (w_count_bin < 12'(FULL_SCALE));
  assign w_inc       = CNT_EN & ~CNT_CLR & w_below_fs;

  bcd_decade u_units (
    .clk    (P1),
    .rst_n  (R),
    .i_clr  (CNT_CLR),
    .i_en   (w_inc),
    .i_cin  (1'b1),
    .o_cout (w_cy_u),
    .o_value(w_units)
  );

  bcd_decade u_tens (
    .clk    (P1),
    .rst_n  (R),
    .i_clr  (CNT_CLR),
    .i_en   (w_inc),
    .i_cin  (w_cy_u),
    .o_cout (w_cy_t),
    .o_value(w_tens)
  );

  bcd_decade u_hund (
    .clk    (P1),
    .rst_n  (R),
    .i_clr  (CNT_CLR),
    .i_en   (w_inc),
    .i_cin  (w_cy_t),
    .o_cout (w_cy_h),
    .o_value(w_hund)
  );

  // Half digit sits outside the decade chain; overflow sticks until the next clear.
  always_ff @(posedge P1 or negedge R) begin
    if (!R) begin
      r_half <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (CNT_CLR) begin
      r_half <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (CNT_EN) begin
      if (!w_below_fs) begin
        r_ovf <= 1'b1;
      end else if (w_cy_h) begin
        r_half <= 1'b1;
      end
    end
  end

  // ---------------- end-of-conversion latch ----------------
  logic r_eoc_in_d;
  logic w_eoc_edge;
  logic r_eoc;
  logic r_half_lat;
  bcd_t r_hund_lat;
  bcd_t r_tens_lat;
  bcd_t r_units_lat;
  logic r_pol_lat;
  logic r_or_lat;
  logic r_ur_lat;

  assign w_eoc_edge = EOC_IN & ~r_eoc_in_d;

  always_ff @(posedge P1 or negedge R) begin
    if (!R) begin
      r_eoc_in_d  <= 1'b0;
      r_eoc       <= 1'b0;
      r_half_lat  <= 1'b0;
      r_hund_lat  <= 4'd0;
      r_tens_lat  <= 4'd0;
      r_units_lat <= 4'd0;
      r_pol_lat   <= 1'b0;
      r_or_lat    <= 1'b0;
      r_ur_lat    <= 1'b0;
    end else begin
      r_eoc_in_d <= EOC_IN;
      r_eoc      <= w_eoc_edge;
      // Counter values here are pre-edge, so a coincident CNT_CLR cannot zero the capture.
      if (w_eoc_edge && DU) begin
        r_half_lat  <= r_half;
        r_hund_lat  <= w_hund;
        r_tens_lat  <= w_tens;
        r_units_lat <= w_units;
        r_pol_lat   <= POL;
        r_or_lat    <= r_ovf;
        r_ur_lat    <= (w_count_bin < 12'(UR_LIMIT)) & ~r_ovf;
      end
    end
  end

  // ---------------- digit scanner ----------------
  dig_t               r_dig;
  dig_t               w_dig_next;
  logic [c_div_w-1:0] r_div;
  logic [c_div_w-1:0] w_div_next;
  logic [3:0]         w_q_word;
  logic [3:0]         r_q;
  logic [3:0]         r_ds;
  logic               r_orb;

  always_ff @(posedge P1 or negedge R) begin
    if (!R) begin
      r_dig <= DIG1;
      r_div <= '0;
    end else begin
      r_dig <= w_dig_next;
      r_div <= w_div_next;
    end
  end

  always_comb begin
    w_dig_next = r_dig;
    w_div_next = r_div + 1'b1;
    if (r_div == c_div_last) begin
      w_div_next = '0;
      case (r_dig)
        DIG1:    w_dig_next = DIG2;
        DIG2:    w_dig_next = DIG3;
        DIG3:    w_dig_next = DIG4;
        default: w_dig_next = DIG1;
      endcase
    end
  end

  // Q is built for the slot being entered so DS and Q move together.
  always_comb begin
    w_q_word = 4'd0;
    case (w_dig_next)
      DIG1:    w_q_word = {r_half_lat, r_pol_lat, 1'b0, r_or_lat | r_ur_lat};
      DIG2:    w_q_word = r_hund_lat;
      DIG3:    w_q_word = r_tens_lat;
      default: w_q_word = r_units_lat;
    endcase
  end

  always_ff @(posedge P1 or negedge R) begin
    if (!R) begin
      r_q   <= 4'd0;
      r_ds  <= c_ds1;
      r_orb <= 1'b1;
    end else begin
      r_q   <= w_q_word;
      r_ds  <= ds_onehot(w_dig_next);
      r_orb <= ~r_or_lat;
    end
  end

  assign Q   = r_q;
  assign DS  = r_ds;
  assign EOC = r_eoc;
  assign ORB = r_orb;

endmodule

`default_nettype wire

// File: tb/tb_mc14433_bcd_latch_scan.sv
// Self-checking bench: integer-level conversion/latch/scan model compared every cycle,
// plus literal digit expectations for the directed conversions.
`default_nettype none

module tb_mc14433_bcd_latch_scan;

  localparam int SCAN_DIV = 4;

  logic       P1 = 1'b0;
  logic       R = 1'b1;
  logic       CNT_EN = 1'b0;
  logic       CNT_CLR = 1'b0;
  logic       EOC_IN = 1'b0;
  logic       POL = 1'b0;
  logic       DU = 1'b0;
  logic [3:0] Q;
  logic [3:0] DS;
  logic       EOC;
  logic       ORB;

  mc14433_bcd_latch_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .FULL_SCALE(1999),
    .UR_LIMIT  (180)
  ) dut (
    .P1     (P1),
    .R      (R),
    .CNT_EN (CNT_EN),
    .CNT_CLR(CNT_CLR),
    .EOC_IN (EOC_IN),
    .POL    (POL),
    .DU     (DU),
    .Q      (Q),
    .DS     (DS),
    .EOC    (EOC),
    .ORB    (ORB)
  );

  always #5 P1 = ~P1;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int   m_count;
  bit   m_ovf;
  bit   m_eoc_prev;
  int   m_tick;
  int   l_val;
  bit   l_pol, l_or, l_ur;
  int   seen_eoc;
  logic [3:0] obs_q [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] word(input int s);
    case (s)
      0:       return {(l_val >= 1000), l_pol, 1'b0, (l_or | l_ur)};
      1:       return 4'((l_val / 100) % 10);
      2:       return 4'((l_val / 10) % 10);
      default: return 4'(l_val % 10);
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_ovf = 0; m_eoc_prev = 0; m_tick = 0;
    l_val = 0; l_pol = 0; l_or = 0; l_ur = 0;
  endtask

  // One P1 cycle: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int         pre;
    bit         pre_ovf, rise;
    int         slot;
    logic [3:0] e_ds, e_q;
    logic       e_eoc, e_orb;
    @(posedge P1);
    pre     = m_count;
    pre_ovf = m_ovf;
    rise    = EOC_IN && !m_eoc_prev;
    m_tick++;
    slot  = (m_tick / SCAN_DIV) % 4;
    e_ds  = 4'(1 << slot);
    e_q   = word(slot);
    e_orb = ~l_or;
    e_eoc = rise;
    if (rise && DU) begin
      l_val = pre; l_pol = POL; l_or = pre_ovf; l_ur = (pre < 180) && !pre_ovf;
    end
    if (CNT_CLR) begin
      m_count = 0; m_ovf = 0;
    end else if (CNT_EN) begin
      if (m_count < 1999) m_count++;
      else m_ovf = 1;
    end
    m_eoc_prev = EOC_IN;
    #1;
    check("cycle {DS,Q,EOC,ORB}", 16'({DS, Q, EOC, ORB}), 16'({e_ds, e_q, e_eoc, e_orb}));
    if (EOC === 1'b1) seen_eoc++;
    for (int k = 0; k < 4; k++) if (DS == 4'(1 << k)) obs_q[k] = Q;
  endtask

  task automatic do_reset();
    #2;
    R = 1'b0;
    #1;
    check("reset outputs", 16'({DS, Q, EOC, ORB}), 16'({4'b0001, 4'b0000, 1'b0, 1'b1}));
    model_reset();
    repeat (3) @(posedge P1);
    #2;
    R = 1'b1;
  endtask

  task automatic convert(input int n, input bit pol, input bit du);
    CNT_CLR = 1; step();
    CNT_CLR = 0; CNT_EN = 1;
    repeat (n) step();
    CNT_EN = 0; POL = pol; DU = du; EOC_IN = 1;
    step();
    EOC_IN = 0;
    step();
  endtask

  task automatic pin(input string name, input logic [3:0] d1, input logic [3:0] d2,
                     input logic [3:0] d3, input logic [3:0] d4, input logic orb);
    repeat (4 * SCAN_DIV + 1) step();
    check({name, " DS1"}, 16'(obs_q[0]), 16'(d1));
    check({name, " DS2"}, 16'(obs_q[1]), 16'(d2));
    check({name, " DS3"}, 16'(obs_q[2]), 16'(d3));
    check({name, " DS4"}, 16'(obs_q[3]), 16'(d4));
    check({name, " ORB"}, 16'(ORB), 16'(orb));
  endtask

  initial begin
    model_reset();
    seen_eoc = 0;
    do_reset();

    // 1: reset mid-count/mid-scan, then scan order with SCAN_DIV=4
    CNT_CLR = 1; step(); CNT_CLR = 0; CNT_EN = 1;
    repeat (567) step();
    CNT_EN = 0;
    do_reset();
    repeat (3) step();
    check("scan hold DS1", 16'(DS), 16'(4'b0001));
    step();
    check("scan DS2", 16'(DS), 16'(4'b0010));
    repeat (4) step();
    check("scan DS3", 16'(DS), 16'(4'b0100));
    repeat (4) step();
    check("scan DS4", 16'(DS), 16'(4'b1000));
    repeat (4) step();
    check("scan wrap DS1", 16'(DS), 16'(4'b0001));

    // 2: 1234, positive
    seen_eoc = 0;
    convert(1234, 1'b1, 1'b1);
    check("eoc pulse count 1234", 16'(seen_eoc), 16'd1);
    pin("1234", 4'b1100, 4'b0010, 4'b0011, 4'b0100, 1'b1);

    // 3: overrange saturation
    convert(2005, 1'b0, 1'b1);
    pin("1999 ovf", 4'b1001, 4'b1001, 4'b1001, 4'b1001, 1'b0);

    // 4: underrange
    convert(150, 1'b0, 1'b1);
    pin("0150 ur", 4'b0001, 4'b0001, 4'b0101, 4'b0000, 1'b1);

    // 5: DU=0 holds the old display; held EOC_IN gives one pulse
    convert(1234, 1'b1, 1'b1);
    seen_eoc = 0;
    convert(42, 1'b0, 1'b0);
    check("eoc pulse DU=0", 16'(seen_eoc), 16'd1);
    pin("DU=0 hold", 4'b1100, 4'b0010, 4'b0011, 4'b0100, 1'b1);
    seen_eoc = 0;
    EOC_IN = 1;
    repeat (10) step();
    EOC_IN = 0;
    step();
    check("eoc held high single", 16'(seen_eoc), 16'd1);

    // 6: clear, enable and EOC edge coincide at 0777
    CNT_CLR = 1; step(); CNT_CLR = 0; CNT_EN = 1;
    repeat (777) step();
    CNT_CLR = 1; DU = 1; POL = 1; EOC_IN = 1;
    step();
    CNT_CLR = 0; CNT_EN = 0; EOC_IN = 0;
    pin("0777 clr", 4'b0100, 4'b0111, 4'b0111, 4'b0111, 1'b1);
    EOC_IN = 1; step(); EOC_IN = 0;
    pin("after clr", 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // randomized conversions with sparse clears, EOC edges and one reset
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 2100);
      if (r == 5) do_reset();
      CNT_CLR = 1; step(); CNT_CLR = 0;
      for (int i = 0; i < n; i++) begin
        CNT_EN  = ($urandom_range(0, 3) != 0);
        CNT_CLR = ($urandom_range(0, 399) == 0);
        EOC_IN  = ($urandom_range(0, 149) == 0);
        DU      = $urandom_range(0, 1);
        POL     = $urandom_range(0, 1);
        step();
      end
      CNT_EN = 0; CNT_CLR = 0; EOC_IN = 0; step();
      DU = 1; POL = $urandom_range(0, 1); EOC_IN = 1; step();
      EOC_IN = 0;
      repeat (4 * SCAN_DIV + 2) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
